parking_manager: RTL and testbench

PARKING_MANAGER -- requirements
Module: parking_manager

---
 rtl/parking_pkg.sv | 17 +
 rtl/parking_manager_if.sv | 33 +++
 rtl/free_space_finder.sv | 21 ++
 rtl/parking_manager.sv | 125 ++++++++++++
 tb/tb_parking_manager.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/parking_pkg.sv
// Shared parking-lot constants, index-width helper and gate FSM encoding.
package parking_pkg;

  localparam int SPACES_DEF      = 8;
  localparam int GATE_CYCLES_DEF = 3;

  // Space-index width, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    OPEN = 1'b1
  } gate_state_e;

endpackage

// File: rtl/parking_manager_if.sv
// Entry/exit request and status bundle between the lot controller and its user.
interface parking_manager_if #(
  parameter int SPACES = parking_pkg::SPACES_DEF
);
  import parking_pkg::*;
  localparam int IDX_W = idx_w(SPACES);

  logic               entry;
  logic               exit_req;
  logic [IDX_W-1:0]   exit_space;
  logic [SPACES-1:0]  parking_capacity;
  logic [IDX_W-1:0]   park_number;
  logic               park_valid;
  logic               entry_reject;
  logic               exit_error;
  logic               gate_open;
  logic               full;
  logic               empty;
  logic [IDX_W:0]     free_count;

  modport master (
    output entry, exit_req, exit_space,
    input  parking_capacity, park_number, park_valid, entry_reject,
           exit_error, gate_open, full, empty, free_count
  );

  modport slave (
    input  entry, exit_req, exit_space,
    output parking_capacity, park_number, park_valid, entry_reject,
           exit_error, gate_open, full, empty, free_count
  );

endinterface

// File: rtl/free_space_finder.sv
// Combinational lowest-index free-space picker over the occupancy bitmap.
module free_space_finder #(
  parameter int SPACES = 8,
  parameter int IDX_W  = 3
) (
  input  logic [SPACES-1:0] bitmap,
  output logic [IDX_W-1:0]  index,
  output logic              any_free
);

  always_comb begin
    index = '0;
    // Scan high to low so the lowest free bit is the last one written.
    for (int i = SPACES - 1; i >= 0; i--) begin
      if (!bitmap[i]) index = IDX_W'(i);
    end
  end

  assign any_free = ~&bitmap;

endmodule

// File: rtl/parking_manager.sv
// Parking lot controller: allocates spaces, drives the entry gate, tracks exits.
module parking_manager
  import parking_pkg::*;
#(
  parameter int SPACES      = SPACES_DEF,
  parameter int GATE_CYCLES = GATE_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  parking_manager_if.slave bus
);

  localparam int IDX_W = idx_w(SPACES);
  localparam int PAD   = 1 << IDX_W;
  localparam int CNT_W = $clog2(GATE_CYCLES + 1);

  gate_state_e       state_q, state_d;
  logic [CNT_W-1:0]  gate_cnt_q, gate_cnt_d;
  logic [SPACES-1:0] bitmap_q, bitmap_d;
  logic [IDX_W-1:0]  park_number_q, park_number_d;
  logic              park_valid_q, park_valid_d;
  logic              entry_reject_q, entry_reject_d;
  logic              exit_error_q, exit_error_d;

  logic [IDX_W-1:0]  free_idx;
  logic              any_free;
  logic [PAD-1:0]    occ_pad, occ_next;
  logic              grant, exit_ok;
  logic [IDX_W:0]    free_cnt;

  free_space_finder #(
    .SPACES (SPACES),
    .IDX_W  (IDX_W)
  ) u_finder (
    .bitmap   (bitmap_q),
    .index    (free_idx),
    .any_free (any_free)
  );

  // Out-of-range exit indices land on padding bits that are always zero,
  // so they read as "already free" and raise exit_error.
  assign occ_pad = PAD'(bitmap_q);
  assign exit_ok = bus.exit_req & occ_pad[bus.exit_space];
  assign grant   = bus.entry & (state_q == IDLE) & any_free;

  always_comb begin
    state_d        = state_q;
    gate_cnt_d     = gate_cnt_q;
    park_number_d  = park_number_q;
    park_valid_d   = 1'b0;
    entry_reject_d = 1'b0;
    exit_error_d   = 1'b0;
    occ_next       = occ_pad;

    if (exit_ok) occ_next[bus.exit_space] = 1'b0;
    else if (bus.exit_req) exit_error_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (grant) begin
          occ_next[free_idx] = 1'b1;
          park_number_d      = free_idx;
          park_valid_d       = 1'b1;
          state_d            = OPEN;
          gate_cnt_d         = CNT_W'(GATE_CYCLES);
        end else if (bus.entry) begin
          entry_reject_d = 1'b1;
        end
      end
      OPEN: begin
        if (bus.entry) entry_reject_d = 1'b1;
        if (gate_cnt_q <= CNT_W'(1)) begin
          state_d    = IDLE;
          gate_cnt_d = '0;
        end else begin
          gate_cnt_d = gate_cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        gate_cnt_d = '0;
      end
    endcase

    bitmap_d = occ_next[SPACES-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      gate_cnt_q     <= '0;
      bitmap_q       <= '0;
      park_number_q  <= '0;
      park_valid_q   <= 1'b0;
      entry_reject_q <= 1'b0;
      exit_error_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      gate_cnt_q     <= gate_cnt_d;
      bitmap_q       <= bitmap_d;
      park_number_q  <= park_number_d;
      park_valid_q   <= park_valid_d;
      entry_reject_q <= entry_reject_d;
      exit_error_q   <= exit_error_d;
    end
  end

  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < SPACES; i++) begin
      free_cnt = free_cnt + (IDX_W+1)'(!bitmap_q[i]);
    end
  end

  assign bus.parking_capacity = bitmap_q;
  assign bus.park_number      = park_number_q;
  assign bus.park_valid       = park_valid_q;
  assign bus.entry_reject     = entry_reject_q;
  assign bus.exit_error       = exit_error_q;
  assign bus.gate_open        = (state_q == OPEN);
  assign bus.full             = &bitmap_q;
  assign bus.empty            = ~|bitmap_q;
  assign bus.free_count       = free_cnt;

endmodule

// File: tb/tb_parking_manager.sv
// Directed bench for parking_manager with SPACES=8, GATE_CYCLES=3.
module tb_parking_manager;

  localparam int SPACES = 8;
  localparam int GATE_CYCLES = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  parking_manager_if #(.SPACES(SPACES)) bus ();

  parking_manager #(
    .SPACES      (SPACES),
    .GATE_CYCLES (GATE_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle entry pulse, then let the gate close so the next entry sees IDLE.
  task automatic park(input logic [2:0] exp_num, input logic [7:0] exp_cap);
    bus.entry = 1'b1;
    tick();
    bus.entry = 1'b0;
    chk("park_valid", bus.park_valid, 1'b1);
    chk("park_number", bus.park_number, exp_num);
    chk("park_cap", bus.parking_capacity, exp_cap);
    repeat (GATE_CYCLES) tick();
    chk("gate_closed", bus.gate_open, 1'b0);
  endtask

  task automatic leave(input logic [2:0] sp, input logic [7:0] exp_cap, input logic exp_err);
    bus.exit_req   = 1'b1;
    bus.exit_space = sp;
    tick();
    bus.exit_req   = 1'b0;
    chk("exit_cap", bus.parking_capacity, exp_cap);
    chk("exit_error", bus.exit_error, exp_err);
  endtask

  initial begin
    bus.entry      = 1'b0;
    bus.exit_req   = 1'b0;
    bus.exit_space = '0;

    // reset state
    tick(); tick();
    reset = 1'b0;
    chk("rst_cap", bus.parking_capacity, 8'h00);
    chk("rst_num", bus.park_number, 3'd0);
    chk("rst_valid", bus.park_valid, 1'b0);
    chk("rst_rej", bus.entry_reject, 1'b0);
    chk("rst_xerr", bus.exit_error, 1'b0);
    chk("rst_gate", bus.gate_open, 1'b0);
    chk("rst_free", bus.free_count, 4'd8);
    chk("rst_empty", bus.empty, 1'b1);
    chk("rst_full", bus.full, 1'b0);

    // first entry: one-cycle latency, gate open for exactly 3 cycles
    bus.entry = 1'b1;
    tick();
    bus.entry = 1'b0;
    chk("e1_valid", bus.park_valid, 1'b1);
    chk("e1_num", bus.park_number, 3'd0);
    chk("e1_cap", bus.parking_capacity, 8'h01);
    chk("e1_free", bus.free_count, 4'd7);
    chk("e1_gate1", bus.gate_open, 1'b1);
    tick();
    chk("e1_valid_drop", bus.park_valid, 1'b0);
    chk("e1_gate2", bus.gate_open, 1'b1);
    tick();
    chk("e1_gate3", bus.gate_open, 1'b1);
    tick();
    chk("e1_gate4", bus.gate_open, 1'b0);

    // fill the remaining spaces in order
    for (int i = 1; i < 8; i++) begin
      logic [7:0] cap;
      cap = 8'((16'd1 << (i + 1)) - 16'd1);
      park(3'(i), cap);
    end
    chk("fill_full", bus.full, 1'b1);
    chk("fill_free", bus.free_count, 4'd0);
    chk("fill_empty", bus.empty, 1'b0);

    // ninth entry bounces off a full lot
    bus.entry = 1'b1;
    tick();
    bus.entry = 1'b0;
    chk("e9_rej", bus.entry_reject, 1'b1);
    chk("e9_valid", bus.park_valid, 1'b0);
    chk("e9_num", bus.park_number, 3'd7);
    chk("e9_gate", bus.gate_open, 1'b0);
    tick();
    chk("e9_rej_drop", bus.entry_reject, 1'b0);

    // exit and entry together while full: exit wins, entry rejected
    bus.entry = 1'b1;
    bus.exit_req = 1'b1;
    bus.exit_space = 3'd3;
    tick();
    bus.entry = 1'b0;
    bus.exit_req = 1'b0;
    chk("xe_rej", bus.entry_reject, 1'b1);
    chk("xe_cap", bus.parking_capacity, 8'hF7);
    chk("xe_valid", bus.park_valid, 1'b0);
    chk("xe_free", bus.free_count, 4'd1);
    chk("xe_full", bus.full, 1'b0);
    park(3'd3, 8'hFF);
    chk("xe_refull", bus.full, 1'b1);

    // entry held through OPEN: rejects on every open cycle
    leave(3'd0, 8'hFE, 1'b0);
    leave(3'd1, 8'hFC, 1'b0);
    bus.entry = 1'b1;
    tick();
    chk("hold_valid", bus.park_valid, 1'b1);
    chk("hold_num", bus.park_number, 3'd0);
    chk("hold_cap0", bus.parking_capacity, 8'hFD);
    for (int c = 0; c < GATE_CYCLES; c++) begin
      tick();
      chk("hold_rej", bus.entry_reject, 1'b1);
      chk("hold_cap", bus.parking_capacity, 8'hFD);
      chk("hold_num_keep", bus.park_number, 3'd0);
    end
    bus.entry = 1'b0;
    tick();
    chk("hold_rej_drop", bus.entry_reject, 1'b0);

    // exit errors: freeing an already-free space
    leave(3'd5, 8'hDD, 1'b0);
    leave(3'd5, 8'hDD, 1'b1);
    tick();
    chk("xerr_drop", bus.exit_error, 1'b0);

    // entry plus exit when not full, then an exit while the gate is open
    bus.entry = 1'b1;
    bus.exit_req = 1'b1;
    bus.exit_space = 3'd7;
    tick();
    bus.entry = 1'b0;
    bus.exit_req = 1'b0;
    chk("both_valid", bus.park_valid, 1'b1);
    chk("both_num", bus.park_number, 3'd1);
    chk("both_cap", bus.parking_capacity, 8'h5F);
    chk("both_xerr", bus.exit_error, 1'b0);
    leave(3'd0, 8'h5E, 1'b0);
    chk("open_exit_gate", bus.gate_open, 1'b1);
    chk("open_exit_free", bus.free_count, 4'd3);

    // reset while OPEN with four spaces taken, entry pending during reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    park(3'd0, 8'h01);
    park(3'd1, 8'h03);
    park(3'd2, 8'h07);
    bus.entry = 1'b1;
    tick();
    chk("r4_cap", bus.parking_capacity, 8'h0F);
    chk("r4_gate", bus.gate_open, 1'b1);
    reset = 1'b1;
    tick();
    chk("rO_cap", bus.parking_capacity, 8'h00);
    chk("rO_gate", bus.gate_open, 1'b0);
    chk("rO_empty", bus.empty, 1'b1);
    chk("rO_free", bus.free_count, 4'd8);
    chk("rO_num", bus.park_number, 3'd0);
    chk("rO_valid", bus.park_valid, 1'b0);
    reset = 1'b0;
    bus.entry = 1'b0;
    tick();
    chk("post_rst_cap", bus.parking_capacity, 8'h00);
    chk("post_rst_valid", bus.park_valid, 1'b0);
    chk("post_rst_rej", bus.entry_reject, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
